iqft3_emulate: RTL

// - Inverse 3-qubit QFT (QFT-dagger) emulator for the state-vector datapath; counterpart of the forward QFT3 block.
// - Captures an 8-amplitude complex state vector on a start handshake.
// - Applies the inverse circuit as a fixed multi-cycle gate schedule and presents the result on held output registers.
// - Result: y[j] = (1/sqrt8) * sum_k x[k]*exp(-i*pi*j*k/4); index k = {b2,b1,b0}, with b2 the MSB.

---
 rtl/iqft3_emulate.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/iqft3_emulate.sv
// Inverse 3-qubit QFT emulator: captures an 8-amplitude complex vector and applies
// bit reversal, Hadamards and phase gates one step per clock, holding the result on registers.
module iqft3_emulate #(
    parameter int                          sample_size    = 8,
    parameter int                          complexnum_bit = 24,
    parameter int                          fp_bit         = 22,
    parameter logic [complexnum_bit-1:0]   mul_h          = 24'h2D413C
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic signed [complexnum_bit-1:0] in_r  [sample_size],
    input  logic signed [complexnum_bit-1:0] in_i  [sample_size],
    output logic signed [complexnum_bit-1:0] out_r [sample_size],
    output logic signed [complexnum_bit-1:0] out_i [sample_size],
    output logic                             busy,
    output logic                             done
);

    localparam int W  = complexnum_bit;
    localparam int PW = 2 * W + 2;

    localparam logic signed [W-1:0] C_H  = $signed(mul_h);
    localparam logic signed [W-1:0] C_NH = -C_H;

    typedef enum logic [2:0] {
        S_IDLE, S_SWAP, S_H0, S_P1, S_H1, S_P2, S_H2, S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;
    logic   w_busy;
    logic   r_done;

    logic signed [W-1:0] r_re      [8];
    logic signed [W-1:0] r_im      [8];
    logic signed [W-1:0] w_re_next [8];
    logic signed [W-1:0] w_im_next [8];

    // Hadamard results for the four pairs of whichever H stage is active
    logic signed [W-1:0] w_hs_re [4];
    logic signed [W-1:0] w_hs_im [4];
    logic signed [W-1:0] w_hd_re [4];
    logic signed [W-1:0] w_hd_im [4];

    // Floor shift by the fraction width, then wrap to W bits.
    function automatic logic signed [W-1:0] trunc_shift(input logic signed [PW-1:0] p);
        return W'(p >>> fp_bit);
    endfunction

    function automatic logic signed [W-1:0] scale_h(input logic signed [W:0] s);
        logic signed [PW-1:0] p;
        p = PW'(s) * PW'(C_H);
        return trunc_shift(p);
    endfunction

    function automatic logic signed [W-1:0] hadamard(input logic signed [W-1:0] a,
                                                     input logic signed [W-1:0] b,
                                                     input logic                sub);
        logic signed [W:0] s;
        s = sub ? ((W+1)'(a) - (W+1)'(b)) : ((W+1)'(a) + (W+1)'(b));
        return scale_h(s);
    endfunction

    function automatic logic signed [W-1:0] cmul_re(input logic signed [W-1:0] ar,
                                                    input logic signed [W-1:0] ai,
                                                    input logic signed [W-1:0] cr,
                                                    input logic signed [W-1:0] ci);
        logic signed [PW-1:0] p;
        p = PW'(ar) * PW'(cr) - PW'(ai) * PW'(ci);
        return trunc_shift(p);
    endfunction

    function automatic logic signed [W-1:0] cmul_im(input logic signed [W-1:0] ar,
                                                    input logic signed [W-1:0] ai,
                                                    input logic signed [W-1:0] cr,
                                                    input logic signed [W-1:0] ci);
        logic signed [PW-1:0] p;
        p = PW'(ar) * PW'(ci) + PW'(ai) * PW'(cr);
        return trunc_shift(p);
    endfunction

    // Pair p of stride s: (a, a+s) with a = (p/s)*2s + p%s
    for (genvar gi = 0; gi < 4; gi++) begin : g_pair
        localparam int A0 = 2 * gi;
        localparam int A1 = (gi / 2) * 4 + (gi % 2);
        localparam int A2 = gi;

        logic signed [W-1:0] w_ar, w_ai, w_br, w_bi;

        always_comb begin
            w_ar = r_re[A0];
            w_ai = r_im[A0];
            w_br = r_re[A0 + 1];
            w_bi = r_im[A0 + 1];
            if (r_state == S_H1) begin
                w_ar = r_re[A1];
                w_ai = r_im[A1];
                w_br = r_re[A1 + 2];
                w_bi = r_im[A1 + 2];
            end else if (r_state == S_H2) begin
                w_ar = r_re[A2];
                w_ai = r_im[A2];
                w_br = r_re[A2 + 4];
                w_bi = r_im[A2 + 4];
            end
        end

        assign w_hs_re[gi] = hadamard(w_ar, w_br, 1'b0);
        assign w_hs_im[gi] = hadamard(w_ai, w_bi, 1'b0);
        assign w_hd_re[gi] = hadamard(w_ar, w_br, 1'b1);
        assign w_hd_im[gi] = hadamard(w_ai, w_bi, 1'b1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        case (r_state)
            S_IDLE: if (start) w_state_next = S_SWAP;
            S_SWAP: begin w_busy = 1'b1; w_state_next = S_H0; end
            S_H0:   begin w_busy = 1'b1; w_state_next = S_P1; end
            S_P1:   begin w_busy = 1'b1; w_state_next = S_H1; end
            S_H1:   begin w_busy = 1'b1; w_state_next = S_P2; end
            S_P2:   begin w_busy = 1'b1; w_state_next = S_H2; end
            S_H2:   begin w_busy = 1'b1; w_state_next = S_DONE; end
            S_DONE: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            w_re_next[k] = r_re[k];
            w_im_next[k] = r_im[k];
        end
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    for (int k = 0; k < 8; k++) begin
                        w_re_next[k] = in_r[k];
                        w_im_next[k] = in_i[k];
                    end
                end
            end
            S_SWAP: begin
                w_re_next[1] = r_re[4]; w_im_next[1] = r_im[4];
                w_re_next[4] = r_re[1]; w_im_next[4] = r_im[1];
                w_re_next[3] = r_re[6]; w_im_next[3] = r_im[6];
                w_re_next[6] = r_re[3]; w_im_next[6] = r_im[3];
            end
            S_H0: begin
                for (int p = 0; p < 4; p++) begin
                    w_re_next[2*p]     = w_hs_re[p]; w_im_next[2*p]     = w_hs_im[p];
                    w_re_next[2*p + 1] = w_hd_re[p]; w_im_next[2*p + 1] = w_hd_im[p];
                end
            end
            S_P1: begin
                w_re_next[3] = r_im[3]; w_im_next[3] = -r_re[3];
                w_re_next[7] = r_im[7]; w_im_next[7] = -r_re[7];
            end
            S_H1: begin
                for (int p = 0; p < 4; p++) begin
                    w_re_next[(p/2)*4 + p%2]     = w_hs_re[p];
                    w_im_next[(p/2)*4 + p%2]     = w_hs_im[p];
                    w_re_next[(p/2)*4 + p%2 + 2] = w_hd_re[p];
                    w_im_next[(p/2)*4 + p%2 + 2] = w_hd_im[p];
                end
            end
            S_P2: begin
                w_re_next[5] = cmul_re(r_re[5], r_im[5], C_H, C_NH);
                w_im_next[5] = cmul_im(r_re[5], r_im[5], C_H, C_NH);
                w_re_next[6] = r_im[6];
                w_im_next[6] = -r_re[6];
                w_re_next[7] = cmul_re(r_re[7], r_im[7], C_NH, C_NH);
                w_im_next[7] = cmul_im(r_re[7], r_im[7], C_NH, C_NH);
            end
            S_H2: begin
                for (int p = 0; p < 4; p++) begin
                    w_re_next[p]     = w_hs_re[p]; w_im_next[p]     = w_hs_im[p];
                    w_re_next[p + 4] = w_hd_re[p]; w_im_next[p + 4] = w_hd_im[p];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 8; k++) begin
                r_re[k] <= '0;
                r_im[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 8; k++) begin
                r_re[k] <= w_re_next[k];
                r_im[k] <= w_im_next[k];
            end
        end
    end

    // done trails the DONE state by one register stage, landing 8 cycles after start
    always_ff @(posedge clk) begin
        if (rst) begin
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == S_DONE);
        end
    end

    assign busy = w_busy;
    assign done = r_done;

    for (genvar gi = 0; gi < 8; gi++) begin : g_out
        assign out_r[gi] = r_re[gi];
        assign out_i[gi] = r_im[gi];
    end

endmodule
